quad_gen: RTL and testbench

Quadrature signal generator: the transmit-side counterpart of the rotary-encoder decoding chain. Given a target position, it emits A/B quadrature waveforms that walk a downstream debounce + encoder pair from the current position to the target, one detent at a time, at a programmable step rate. Used as an on-chip encoder emulator for self-test and to drive PWM channels over the same A/B interface that the physical knobs use.

---
 rtl/quad_gen.sv | 115 +++++++++++
 tb/tb_quad_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// Quadrature A/B generator: walks a downstream encoder from the
// current position to a loaded target, one detent per 4 edges.
module quad_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target,
  input  logic [DIV_W-1:0] period,
  input  logic             load,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam logic [DIV_W-1:0] T_ONE = DIV_W'(1);
  localparam logic [WIDTH-1:0] P_ONE = WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt, tgt_n, pos_n, diff;
  logic [DIV_W-1:0] per, per_n, p_in;
  logic [DIV_W-1:0] timer, timer_n;
  logic [1:0]       phase, phase_n;
  logic             dir, dir_n, up, done_n;

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    per_n   = per;
    timer_n = timer;
    phase_n = phase;
    dir_n   = dir;
    pos_n   = position;
    done_n  = 1'b0;
    p_in    = (period == '0) ? T_ONE : period;
    if (load) begin
      tgt_n = target;
      per_n = p_in;
    end
    diff = tgt_n - position;
    // Direction is only re-chosen on a detent boundary.
    up = (phase == 2'd0) ? ~diff[WIDTH-1] : dir;
    unique case (state)
      IDLE: begin
        if (load) begin
          if (diff == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            timer_n = p_in - T_ONE;
          end
        end
      end
      RUN: begin
        if (timer != '0) begin
          timer_n = timer - T_ONE;
        end else begin
          timer_n = per_n - T_ONE;
          if (phase == 2'd0 && diff == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            dir_n   = up;
            phase_n = up ? phase + 2'd1
                         : phase - 2'd1;
            if (phase_n == 2'd0) begin
              pos_n = up ? position + P_ONE
                         : position - P_ONE;
              if (pos_n == tgt_n) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tgt      <= '0;
      per      <= T_ONE;
      timer    <= '0;
      phase    <= 2'd0;
      dir      <= 1'b0;
      position <= '0;
      done     <= 1'b0;
      a        <= 1'b0;
      b        <= 1'b0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      per      <= per_n;
      timer    <= timer_n;
      phase    <= phase_n;
      dir      <= dir_n;
      position <= pos_n;
      done     <= done_n;
      // phase index 0..3 maps to Gray (a,b) = 00,10,11,01
      a        <= ^phase_n;
      b        <= phase_n[1];
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_quad_gen.sv
// Directed bench for quad_gen: table of moves checked cycle by
// cycle, plus reset and mid-detent retarget sequences.
module tb_quad_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  target;
  logic [15:0] period;
  logic        a, b, busy, done;
  logic [7:0]  position;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  quad_gen #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .target(target),
    .period(period),
    .load(load),
    .a(a),
    .b(b),
    .position(position),
    .busy(busy),
    .done(done)
  );

  typedef struct {
    logic [7:0]  tgt;
    logic [15:0] per;
    int          p;
    int          d;
    bit          up;
    logic [7:0]  fin;
  } vec_t;

  vec_t v[9];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] obs();
    return {20'd0, a, b, busy, done, position};
  endfunction

  task automatic move(int idx, vec_t t, logic [7:0] start);
    int tot, e;
    logic [1:0] ab;
    logic [7:0] pos;
    target = t.tgt;
    period = t.per;
    load = 1'b1;
    step();
    load = 1'b0;
    tot = 4 * t.p * t.d;
    for (int k = 0; k <= tot + 2; k++) begin
      e = k / t.p;
      if (e > 4 * t.d) e = 4 * t.d;
      case (e % 4)
        0: ab = 2'b00;
        1: ab = t.up ? 2'b10 : 2'b01;
        2: ab = 2'b11;
        default: ab = t.up ? 2'b01 : 2'b10;
      endcase
      pos = t.up ? start + 8'(e / 4) : start - 8'(e / 4);
      chk($sformatf("move%0d k%0d", idx, k), obs(),
          {20'd0, ab, 1'(k < tot), 1'(k == tot), pos});
      step();
    end
    chk($sformatf("move%0d final", idx), {24'd0, position},
        {24'd0, t.fin});
  endtask

  initial begin
    logic [7:0] cur;
    int ndone, dk;

    v[0] = '{8'd3,   16'd2, 2, 3,   1'b1, 8'd3};
    v[1] = '{8'd3,   16'd5, 5, 0,   1'b1, 8'd3};
    v[2] = '{8'd1,   16'd1, 1, 2,   1'b0, 8'd1};
    v[3] = '{8'd255, 16'd0, 1, 2,   1'b0, 8'd255};
    v[4] = '{8'd0,   16'd3, 3, 1,   1'b1, 8'd0};
    v[5] = '{8'd254, 16'd1, 1, 2,   1'b0, 8'd254};
    v[6] = '{8'd0,   16'd2, 2, 2,   1'b1, 8'd0};
    v[7] = '{8'd128, 16'd0, 1, 128, 1'b0, 8'd128};
    v[8] = '{8'd0,   16'd1, 1, 128, 1'b0, 8'd0};

    reset  = 1'b1;
    load   = 1'b1;
    target = 8'd7;
    period = 16'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("reset hold %0d", i), obs(), 32'd0);
    end
    reset = 1'b0;
    load  = 1'b0;
    step();
    chk("reset release", obs(), 32'd0);

    target = 8'd10;
    load = 1'b1;
    step();
    load = 1'b0;
    chk("premove busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    chk("midmove reset", obs(), 32'd0);
    reset = 1'b0;
    step();
    chk("after midmove reset", obs(), 32'd0);

    cur = 8'd0;
    for (int i = 0; i < 9; i++) begin
      move(i, v[i], cur);
      cur = v[i].fin;
    end

    ndone = 0;
    dk = -1;
    target = 8'd5;
    period = 16'd3;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (done) begin
        ndone++;
        dk = k;
      end
      if (k == 18) begin
        chk("retarget pre", {22'd0, a, b, position}, {22'd0, 2'b11, 8'd1});
        target = 8'd0;
        load = 1'b1;
      end
      if (k == 19) load = 1'b0;
      if (k == 24)
        chk("retarget detent2", {22'd0, a, b, position}, {22'd0, 2'b00, 8'd2});
      if (k == 27)
        chk("retarget reverse", {30'd0, a, b}, {30'd0, 2'b01});
      step();
    end
    chk("retarget done count", ndone, 32'd1);
    chk("retarget done cycle", dk, 32'd48);
    chk("retarget final", {23'd0, busy, position}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
